pdm_cic_decimator: RTL and testbench
====================================

# pdm_cic_decimator

Front-end decimator for the spectrum analyzer. It converts the 1-bit pulse-density audio stream on the audio input pin into signed 8-bit PCM samples with a one-cycle valid strobe, using a 2nd-order CIC filter. It sits directly upstream of the filter bank and energy stage, and replaces the simple count-ones accumulator with a properly decimated, low-pass-filtered sample.

## Interface
Parameters:
- `DECIM`, default 64: decimation ratio R. Legal values are 16, 32 and 64 only.
- `LOG2R`, default `$clog2(DECIM)`: derived; do not override.

Ports:
- `clk` input 1: system clock. Single clock domain.
- `rst` input 1: asynchronous, active-high reset.
- `pdm_in` input 1: PDM bit. It is sampled only on cycles where `in_en`=1.
- `in_en` input 1: input-rate strobe. May be high every cycle or sparsely; there is no minimum gap.
- `sample_out` output 8: signed 2's-complement PCM sample. Holds its value between strobes.
- `sample_valid` output 1: one-cycle pulse; `sample_out` is new in that cycle.
- `clip` output 1: qualified by `sample_valid`. High when the current sample was saturated.

## Operation
- Input mapping: `pdm_in`=1 maps to +1 and 0 maps to −1. This is a signed input to the first integrator.
- Internal width W = 2·LOG2R + 2 bits, signed. All integrators, comb delays and differences are W bits with modular (wrap-around) arithmetic. Wrap is intentional and must not be detected or saturated.
- Integrator stage, updated only when `in_en`=1:
  - I1 ← I1 + x
  - I2 ← I2 + I1 (new I1)
- Block counter: LOG2R bits, increments on each `in_en`.
  - The `in_en` that moves the counter from R−1 to 0 completes a block.
  - On that same edge, capture I2 (its post-update value) into `cap` and set `tick`.
- Comb stage, on the cycle after `tick`:
  - c1 = cap − D1, then D1 ← cap
  - c2 = c1 − D2, then D2 ← c1
- Output scaling: y = c2 >>> (2·LOG2R − 7), arithmetic shift.
  - Saturate y to [−128, 127]; `clip` = 1 if saturation occurred.
  - The full-scale +1 stream gives +R², which becomes +128, saturates to 127 with `clip`=1.
  - The full-scale −1 stream gives −128 with `clip`=0.
- Warm-up: a 2-bit counter suppresses `sample_valid` for the first two completed blocks after reset.
  - Comb registers still update during those blocks.
  - The third block is the first valid output and is exact for constant-density input.
  - The counter saturates at 2.
- Reset (asserted at any time, including mid-block or mid-pipeline):
  - I1, I2, `cap`, D1, D2, block counter, `tick`, warm-up counter → 0.
  - `sample_out` = 8'h00, `sample_valid` = 0, `clip` = 0, asynchronously.
  - Any in-flight block is discarded. After release, warm-up restarts.
- `in_en` sampled high on the same edge that the comb/output stage fires has no interaction; the integrators are independent of the comb stage.
- `pdm_in` is ignored whenever `in_en`=0.

## Timing
- Edge E0 samples the block-completing `in_en`. The integrators update and `tick` is set.
- Edge E1: comb computes; D1 and D2 update; `sample_out`, `clip` and `sample_valid` are registered.
- Latency: `sample_valid` is high in the cycle following E1, i.e. 2 edges after E0. It lasts exactly 1 cycle.
- With `in_en` continuously high, valids occur every R cycles. With `in_en` every k cycles, valids occur every k·R cycles.
- No backpressure: the consumer must accept each sample in its valid cycle.
- `sample_out` and `clip` remain stable until the next valid.

## Test plan
- Reset/idle, DECIM=64, `in_en`=1 continuously:
  - Assert `rst` mid-block → outputs 0 immediately.
  - After release with `pdm_in`=1, the first `sample_valid` comes 3·64 in_en cycles + 2 edges later.
- All-ones, DECIM=64, `in_en` every cycle → every valid gives `sample_out`=127, `clip`=1, period 64 cycles. All-zeros → −128, `clip`=0.
- Alternating 1,0 → `sample_out`=0, `clip`=0. Repeating 1,1,1,0 (75% density) → `sample_out`=64. Repeating 1,0,0,0 → −64.
- Sparse strobe: `in_en` one cycle in 64, 75% pattern → outputs of 64 spaced 4096 cycles apart. Toggling `pdm_in` on non-enabled cycles has no effect.
- DECIM=16 with all-ones for ≥1000 blocks:
  - Output stays 127/`clip`=1. This proves the W=10 integrators wrap correctly.
  - Switch to 50% density → output 0 from the second valid after the switch.
- Reset mid-pipeline: assert `rst` on the edge between E0 and E1 → no `sample_valid` pulse appears, and warm-up restarts (two suppressed blocks).

Source files
------------

// File: rtl/pdm_cic_decimator_if.sv
// PDM input stream and decimated PCM output bundle for the CIC decimator.
// The master side feeds PDM bits and consumes samples; the slave side is the decimator.
interface pdm_cic_decimator_if;
  logic       pdm_in;
  logic       in_en;
  logic [7:0] sample_out;
  logic       sample_valid;
  logic       clip;

  modport master (
    output pdm_in, in_en,
    input  sample_out, sample_valid, clip
  );

  modport slave (
    input  pdm_in, in_en,
    output sample_out, sample_valid, clip
  );
endinterface

// File: rtl/pdm_cic_decimator.sv
// Second-order CIC decimator: 1-bit PDM in, signed 8-bit PCM out with a valid strobe.
// DECIM may only be 16, 32 or 64; LOG2R is derived from it and is not meant to be overridden.
// All internal arithmetic is W-bit modular; integrator wrap is expected and cancels in the combs.
module pdm_cic_decimator #(
  parameter int DECIM = 64,
  parameter int LOG2R = $clog2(DECIM)
) (
  input logic clk,
  input logic rst,
  pdm_cic_decimator_if.slave bus
);

  localparam int W     = 2 * LOG2R + 2;
  localparam int SHIFT = 2 * LOG2R - 7;

  // Saturation limits; -128 is the bitwise inverse of +127 in any width
  localparam logic signed [W-1:0] Y_MAX = W'(127);
  localparam logic signed [W-1:0] Y_MIN = ~Y_MAX;

  logic signed [W-1:0] i1;
  logic signed [W-1:0] i2;
  logic signed [W-1:0] cap;
  logic signed [W-1:0] d1;
  logic signed [W-1:0] d2;
  logic [LOG2R-1:0]    blk_cnt;
  logic                tick;
  logic [1:0]          warm;

  logic signed [W-1:0] x;
  logic signed [W-1:0] i1_next;
  logic signed [W-1:0] i2_next;
  logic signed [W-1:0] c1;
  logic signed [W-1:0] c2;
  logic signed [W-1:0] y;
  logic [7:0]          y_sat;
  logic                y_clip;

  logic [7:0]          sample_q;
  logic                valid_q;
  logic                clip_q;

  // Bipolar input mapping and the next integrator values for the current strobe
  always_comb begin
    x       = bus.pdm_in ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};
    i1_next = i1 + x;
    i2_next = i2 + i1_next;
  end

  // Integrators and block counter advance only on input strobes; the last strobe of a block captures I2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i1      <= '0;
      i2      <= '0;
      cap     <= '0;
      blk_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (bus.in_en) begin
        i1      <= i1_next;
        i2      <= i2_next;
        blk_cnt <= blk_cnt + LOG2R'(1);
        if (blk_cnt == {LOG2R{1'b1}}) begin
          cap  <= i2_next;
          tick <= 1'b1;
        end
      end
    end
  end

  // Two comb differences, gain normalisation and saturation to the 8-bit output range
  always_comb begin
    c1     = cap - d1;
    c2     = c1 - d2;
    y      = c2 >>> SHIFT;
    y_sat  = y[7:0];
    y_clip = 1'b0;
    if (y > Y_MAX) begin
      y_sat  = 8'h7F;
      y_clip = 1'b1;
    end else if (y < Y_MIN) begin
      y_sat  = 8'h80;
      y_clip = 1'b1;
    end
  end

  // Comb delays update every block; outputs are only published once the two warm-up blocks have passed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1       <= '0;
      d2       <= '0;
      warm     <= 2'd0;
      sample_q <= 8'h00;
      valid_q  <= 1'b0;
      clip_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (tick) begin
        d1 <= cap;
        d2 <= c1;
        if (warm == 2'd2) begin
          valid_q  <= 1'b1;
          sample_q <= y_sat;
          clip_q   <= y_clip;
        end else begin
          warm <= warm + 2'd1;
        end
      end
    end
  end

  assign bus.sample_out   = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.clip         = clip_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for the CIC decimator: one R=64 and one R=16 instance on a shared clock and reset.
module tb_pdm_cic_decimator;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks   = 0;
  int failures = 0;
  int en_idx64 = 0;
  int en_idx16 = 0;

  pdm_cic_decimator_if bus64 ();
  pdm_cic_decimator_if bus16 ();

  pdm_cic_decimator #(.DECIM(64)) dut64 (
    .clk (clk),
    .rst (rst),
    .bus (bus64.slave)
  );

  pdm_cic_decimator #(.DECIM(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic driveBus(input int which, input logic en, input logic b);
    if (which == 16) begin
      bus16.in_en  = en;
      bus16.pdm_in = b;
    end else begin
      bus64.in_en  = en;
      bus64.pdm_in = b;
    end
  endtask

  // Called #1 after an active edge; asserts reset mid-cycle, checks the async clear, releases after two edges
  task automatic pulseReset(input string tag);
    #3 rst = 1'b1;
    driveBus(64, 1'b0, 1'b0);
    driveBus(16, 1'b0, 1'b0);
    #1;
    checkOutput({tag, "_out64"},   $signed(bus64.sample_out), 0);
    checkOutput({tag, "_clip64"},  bus64.clip, 0);
    checkOutput({tag, "_valid64"}, bus64.sample_valid, 0);
    checkOutput({tag, "_out16"},   $signed(bus16.sample_out), 0);
    en_idx64 = 0;
    en_idx16 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Runs ncycles of stimulus (strobe every en_every cycles, pattern bits per strobe), plus 3 idle
  // cycles when flush is set; checks each valid after the first 'skip', spacing, first index and count
  task automatic applyStimulus(input int which, input int ncycles, input logic [3:0] pat,
                               input int plen, input int en_every, input bit flush, input int skip,
                               input logic signed [31:0] exp_val, input logic exp_clip,
                               input int exp_period, input int exp_first, input int exp_count,
                               input string tag);
    int nval;
    int last_c;
    int total;
    logic en;
    logic b;
    logic v;
    logic signed [7:0] so;
    logic cl;
    nval   = 0;
    last_c = 0;
    total  = flush ? ncycles + 3 : ncycles;
    for (int c = 0; c < total; c++) begin
      en = (c < ncycles) && (c % en_every == 0);
      if (en) begin
        if (which == 16) begin
          b = pat[en_idx16 % plen];
          en_idx16++;
        end else begin
          b = pat[en_idx64 % plen];
          en_idx64++;
        end
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      driveBus(which, en, b);
      @(posedge clk);
      #1;
      if (which == 16) begin
        v  = bus16.sample_valid;
        so = bus16.sample_out;
        cl = bus16.clip;
      end else begin
        v  = bus64.sample_valid;
        so = bus64.sample_out;
        cl = bus64.clip;
      end
      if (v) begin
        nval++;
        if (nval == 1 && exp_first >= 0) checkOutput({tag, "_first"}, c, exp_first);
        if (nval > skip) begin
          checkOutput({tag, "_val"}, so, exp_val);
          checkOutput({tag, "_clip"}, cl, exp_clip);
        end
        if (nval > 1) checkOutput({tag, "_period"}, c - last_c, exp_period);
        last_c = c;
      end
    end
    driveBus(which, 1'b0, 1'b0);
    checkOutput({tag, "_count"}, nval, exp_count);
  endtask

  initial begin
    driveBus(64, 1'b0, 1'b0);
    driveBus(16, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    $display("[TB] reset and warm-up latency, R=64");
    pulseReset("init");
    applyStimulus(64, 384, 4'b1111, 1, 1, 1'b1, 0, 127, 1'b1, 64, 192, 4, "ones64");

    $display("[TB] reset in the middle of a block");
    applyStimulus(64, 32, 4'b1111, 1, 1, 1'b0, 0, 127, 1'b1, 64, -1, 0, "midblk_run");
    pulseReset("midblk");

    $display("[TB] constant-density patterns, R=64");
    applyStimulus(64, 320, 4'b0000, 1, 1, 1'b1, 0, -128, 1'b0, 64, 192, 3, "zeros64");
    applyStimulus(64, 320, 4'b0101, 2, 1, 1'b1, 1, 0, 1'b0, 64, -1, 5, "alt64");
    applyStimulus(64, 320, 4'b0111, 4, 1, 1'b1, 1, 64, 1'b0, 64, -1, 5, "d75_64");
    applyStimulus(64, 320, 4'b0001, 4, 1, 1'b1, 1, -64, 1'b0, 64, -1, 5, "d25_64");

    $display("[TB] reset between block completion and comb stage");
    pulseReset("pre_pipe");
    applyStimulus(64, 192, 4'b1111, 1, 1, 1'b0, 0, 127, 1'b1, 64, -1, 0, "pipe_run");
    pulseReset("pipe");
    applyStimulus(64, 256, 4'b1111, 1, 1, 1'b1, 0, 127, 1'b1, 64, 192, 2, "after_pipe");

    $display("[TB] sparse strobe, one in 64 cycles");
    pulseReset("pre_sparse");
    applyStimulus(64, 16384, 4'b0111, 4, 64, 1'b1, 0, 64, 1'b0, 4096, 12225, 2, "sparse");

    $display("[TB] R=16 long run and density switch");
    pulseReset("pre_r16");
    applyStimulus(16, 16000, 4'b1111, 1, 1, 1'b1, 0, 127, 1'b1, 16, 48, 998, "ones16");
    applyStimulus(16, 160, 4'b0101, 2, 1, 1'b1, 1, 0, 1'b0, 16, -1, 10, "half16");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
